// File: rtl/reg_pkg.sv
// Register-file constants and the dump FSM state type.
// Optional macro REG_DUMP_CHECKSUM_EN adds the trailing checksum state.
package reg_pkg;
    localparam int REG_ADDR_W = 3;
    localparam int REG_DATA_W = 8;
    localparam int NUM_REGS   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SEND1 = 3'd3,
        ST_SEND2 = 3'd4,
`ifdef REG_DUMP_CHECKSUM_EN
        ST_CSUM  = 3'd6,
`endif
        ST_FIN   = 3'd5
    } dump_state_t;
endpackage

// File: rtl/reg_file_dump.sv
// Scan-out initiator: reads the register file two registers at a time and streams the bytes.
// Optional macro REG_DUMP_CHECKSUM_EN appends a modulo-2**DATA_WIDTH sum byte to the stream.
module reg_file_dump #(
    parameter int NUM_REGS   = reg_pkg::NUM_REGS,
    parameter int DATA_WIDTH = reg_pkg::REG_DATA_W,
    parameter int ADDR_WIDTH = reg_pkg::REG_ADDR_W,
    parameter int READ_LAT   = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic                  ABORT,
    output logic [ADDR_WIDTH-1:0] READADDR1,
    output logic [ADDR_WIDTH-1:0] READADDR2,
    input  logic [DATA_WIDTH-1:0] REGDATA1,
    input  logic [DATA_WIDTH-1:0] REGDATA2,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic                  DVALID,
    input  logic                  DREADY,
    output logic                  DLAST,
    output logic                  BUSY,
    output logic                  DONE
);
    import reg_pkg::*;

    localparam int PAIR_W = (NUM_REGS > 2) ? $clog2(NUM_REGS / 2) : 1;
    localparam int WAIT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_REGS / 2 - 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(READ_LAT - 1);

    dump_state_t           state_reg, state_next;
    logic [PAIR_W-1:0]     k_reg, k_next;
    logic [WAIT_W-1:0]     wait_reg, wait_next;
    logic [DATA_WIDTH-1:0] c1_reg, c1_next;
    logic [DATA_WIDTH-1:0] c2_reg, c2_next;
    logic [ADDR_WIDTH-1:0] addr1_reg, addr1_next;
    logic [ADDR_WIDTH-1:0] addr2_reg, addr2_next;
    logic                  last_pair;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_reg, sum_next;
`endif

    assign last_pair = (k_reg == LAST_PAIR);
    assign READADDR1 = addr1_reg;
    assign READADDR2 = addr2_reg;
    assign BUSY      = (state_reg != ST_IDLE);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg <= ST_IDLE;
            k_reg     <= '0;
            wait_reg  <= '0;
            c1_reg    <= '0;
            c2_reg    <= '0;
            addr1_reg <= ADDR_WIDTH'(0);
            addr2_reg <= ADDR_WIDTH'(1);
`ifdef REG_DUMP_CHECKSUM_EN
            sum_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            wait_reg  <= wait_next;
            c1_reg    <= c1_next;
            c2_reg    <= c2_next;
            addr1_reg <= addr1_next;
            addr2_reg <= addr2_next;
`ifdef REG_DUMP_CHECKSUM_EN
            sum_reg   <= sum_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        wait_next  = wait_reg;
        c1_next    = c1_reg;
        c2_next    = c2_reg;
        addr1_next = addr1_reg;
        addr2_next = addr2_reg;
`ifdef REG_DUMP_CHECKSUM_EN
        sum_next   = sum_reg;
`endif
        DOUT   = '0;
        DVALID = 1'b0;
        DLAST  = 1'b0;
        DONE   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (START) begin
                    k_next     = '0;
                    state_next = ST_RD;
`ifdef REG_DUMP_CHECKSUM_EN
                    sum_next   = '0;
`endif
                end
            end
            ST_RD: begin
                wait_next  = WAIT_INIT;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_reg != '0) begin
                    wait_next = wait_reg - 1'b1;
                end else begin
                    c1_next    = REGDATA1;
                    c2_next    = REGDATA2;
                    state_next = ST_SEND1;
                end
            end
            ST_SEND1: begin
                DOUT   = c1_reg;
                DVALID = 1'b1;
                if (DREADY) begin
                    state_next = ST_SEND2;
`ifdef REG_DUMP_CHECKSUM_EN
                    sum_next   = sum_reg + c1_reg;
`endif
                end
            end
            ST_SEND2: begin
                DOUT   = c2_reg;
                DVALID = 1'b1;
`ifndef REG_DUMP_CHECKSUM_EN
                DLAST  = last_pair;
`endif
                if (DREADY) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    sum_next = sum_reg + c2_reg;
`endif
                    if (last_pair) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        state_next = ST_CSUM;
`else
                        state_next = ST_FIN;
`endif
                    end else begin
                        k_next     = k_reg + 1'b1;
                        state_next = ST_RD;
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                DOUT   = sum_reg;
                DVALID = 1'b1;
                DLAST  = 1'b1;
                if (DREADY) begin
                    state_next = ST_FIN;
                end
            end
`endif
            ST_FIN: begin
                DONE       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // Abort wins over everything, including START and a pending DONE.
        if (ABORT) begin
            state_next = ST_IDLE;
            DONE       = 1'b0;
        end

        // Addresses change only on entry to RD and then hold for the whole pair.
        if (state_next == ST_RD && state_reg != ST_RD) begin
            addr1_next = ADDR_WIDTH'({k_next, 1'b0});
            addr2_next = ADDR_WIDTH'({k_next, 1'b1});
        end
    end
endmodule

// File: tb/tb_reg_file_dump.sv
// Directed self-checking bench for reg_file_dump with a synchronous-read register file model.
// Define REG_DUMP_CHECKSUM_EN to exercise the checksum byte.
module tb_reg_file_dump;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic       DREADY = 1'b0;
    logic [2:0] READADDR1, READADDR2;
    logic [7:0] REGDATA1, REGDATA2;
    logic [7:0] DOUT;
    logic       DVALID, DLAST, BUSY, DONE;

    logic [7:0] rf [0:7];
    logic       rf_we = 1'b0;
    logic [2:0] rf_wa = '0;
    logic [7:0] rf_wd = '0;

    logic [7:0] exp_vals [0:8];
    int         exp_len = 8;
    int         checks = 0;
    int         errors = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (rf_we) rf[rf_wa] <= rf_wd;
        REGDATA1 <= rf[READADDR1];
        REGDATA2 <= rf[READADDR2];
    end

    reg_file_dump dut (
        .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
        .READADDR1(READADDR1), .READADDR2(READADDR2),
        .REGDATA1(REGDATA1), .REGDATA2(REGDATA2),
        .DOUT(DOUT), .DVALID(DVALID), .DREADY(DREADY), .DLAST(DLAST),
        .BUSY(BUSY), .DONE(DONE)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Writes the register file and builds the expected stream.
    task automatic load_regs(input bit all_ff);
        logic [7:0] v;
        logic [7:0] sum;
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            v = all_ff ? 8'hFF : 8'h10 + 8'(i);
            @(negedge CLK);
            rf_we = 1'b1;
            rf_wa = 3'(i);
            rf_wd = v;
            exp_vals[i] = v;
            sum = sum + v;
        end
        @(negedge CLK);
        rf_we = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
        exp_vals[8] = sum;
        exp_len = 9;
`else
        exp_vals[8] = '0;
        exp_len = 8;
`endif
    endtask

    task automatic run_dump(input bit stall, input bit restart, input int abort_at, input int rst_at);
        int         n;
        bit         prev_stall;
        logic [7:0] prev_dout;
        bit         expect_done;
        bit         finished;
        bit         bail;
        bit   [7:0] pat;
        n = 0; prev_stall = 0; prev_dout = '0; expect_done = 0; finished = 0; bail = 0;
        pat = 8'b0110_1001;
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        for (int cyc = 0; cyc < 400 && !finished && !bail; cyc++) begin
            START = 1'b0;
            if (expect_done) begin
                chk("done_pulse", 32'(DONE), 1);
                chk("busy_in_fin", 32'(BUSY), 1);
                @(negedge CLK);
                chk("done_single", 32'(DONE), 0);
                chk("busy_after", 32'(BUSY), 0);
                finished = 1;
            end else begin
                if (DONE) chk("done_early", 32'(DONE), 0);
                if (prev_stall) begin
                    chk("stall_dvalid", 32'(DVALID), 1);
                    chk("stall_dout", 32'(DOUT), 32'(prev_dout));
                end
                DREADY = stall ? pat[cyc[2:0]] : 1'b1;
                if (DVALID && n == abort_at) begin
                    DREADY = 1'b0;
                    ABORT  = 1'b1;
                    @(negedge CLK);
                    ABORT = 1'b0;
                    chk("abort_dvalid", 32'(DVALID), 0);
                    chk("abort_dlast", 32'(DLAST), 0);
                    chk("abort_busy", 32'(BUSY), 0);
                    repeat (4) begin
                        chk("abort_no_done", 32'(DONE), 0);
                        @(negedge CLK);
                    end
                    $display("abort after %0d bytes", n);
                    bail = 1;
                end else if (DVALID && n == rst_at) begin
                    DREADY = 1'b0;
                    chk("pre_rst_addr1", 32'(READADDR1), 32'(2 * (n / 2)));
                    #1 RESET = 1'b0;
                    #1;
                    chk("rst_addr1", 32'(READADDR1), 0);
                    chk("rst_addr2", 32'(READADDR2), 1);
                    chk("rst_dout", 32'(DOUT), 0);
                    chk("rst_dvalid", 32'(DVALID), 0);
                    chk("rst_dlast", 32'(DLAST), 0);
                    chk("rst_busy", 32'(BUSY), 0);
                    chk("rst_done", 32'(DONE), 0);
                    $display("reset mid-dump after %0d bytes", n);
                    @(negedge CLK);
                    RESET = 1'b1;
                    bail = 1;
                end else begin
                    if (DVALID && DREADY) begin
                        chk("byte", 32'(DOUT), 32'(exp_vals[n]));
                        chk("dlast", 32'(DLAST), 32'(n == exp_len - 1));
                        $display("byte %0d = %02h last=%0b", n, DOUT, DLAST);
                        n++;
                        if (n == exp_len) expect_done = 1;
                        if (restart && n == 3) START = 1'b1;
                    end
                    prev_stall = DVALID && !DREADY;
                    prev_dout  = DOUT;
                    @(negedge CLK);
                end
            end
        end
        if (!bail) chk("dump_complete", 32'(finished), 1);
    endtask

    initial begin
        #1 RESET = 1'b0;
        #2;
        chk("init_addr1", 32'(READADDR1), 0);
        chk("init_addr2", 32'(READADDR2), 1);
        chk("init_dout", 32'(DOUT), 0);
        chk("init_dvalid", 32'(DVALID), 0);
        chk("init_dlast", 32'(DLAST), 0);
        chk("init_busy", 32'(BUSY), 0);
        chk("init_done", 32'(DONE), 0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;

        load_regs(1'b0);
        run_dump(1'b0, 1'b0, -1, -1);
        run_dump(1'b1, 1'b0, -1, -1);
        run_dump(1'b0, 1'b1, -1, -1);
        run_dump(1'b0, 1'b0, 4, -1);
        run_dump(1'b0, 1'b0, -1, -1);
        run_dump(1'b1, 1'b0, -1, 3);
        run_dump(1'b0, 1'b0, -1, -1);
`ifdef REG_DUMP_CHECKSUM_EN
        load_regs(1'b1);
        chk("csum_model", 32'(exp_vals[8]), 32'h0000_00F8);
        run_dump(1'b0, 1'b0, -1, -1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/reg_file_dump.md
Name: reg_file_dump

Overview:
- Read-side initiator for the 8x8 register file.
- On a START pulse, it walks every register through the file's two read ports, two registers per read.
- Each value is captured and streamed out as a byte stream with a valid/ready handshake.
- Used as the debug/scan-out path beside the CPU datapath. The CPU must hold off register writes while BUSY is high.

Parameters:
- NUM_REGS, 8, number of registers scanned; must be even and at least 2.
- DATA_WIDTH, 8, register and stream byte width.
- ADDR_WIDTH, 3, register address width; 2**ADDR_WIDTH must be at least NUM_REGS.
- READ_LAT, 1, cycles from driving the read addresses to sampling REGDATA1/2; at least 1.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle request to begin a dump.
- ABORT  in  1  synchronous abort of a dump in progress.
- READADDR1  out  ADDR_WIDTH  read address to register file port 1.
- READADDR2  out  ADDR_WIDTH  read address to register file port 2.
- REGDATA1  in  DATA_WIDTH  register file read data, port 1.
- REGDATA2  in  DATA_WIDTH  register file read data, port 2.
- DOUT  out  DATA_WIDTH  stream byte.
- DVALID  out  1  DOUT is valid.
- DREADY  in  1  sink accepts; a transfer happens when DVALID and DREADY are both high on a clock edge.
- DLAST  out  1  marks the final byte of the dump.
- BUSY  out  1  high from the cycle after START is accepted until return to IDLE.
- DONE  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE; READADDR1=0, READADDR2=1; DOUT=0; DVALID=0; DLAST=0; BUSY=0; DONE=0; pair index=0; wait counter=0.
- States: IDLE, RD, WAIT, SEND1, SEND2, FIN.
- IDLE:
  - START=1 -> go to RD, pair index k=0.
  - START is ignored in every other state.
- RD:
  - Drive READADDR1=2k, READADDR2=2k+1.
  - Load the wait counter with READ_LAT-1, go to WAIT.
  - Addresses stay stable until the next RD.
- WAIT:
  - Counter nonzero -> decrement it.
  - Counter zero -> register REGDATA1 and REGDATA2 into capture regs C1 and C2, go to SEND1.
  - Net latency from entering RD to capture is READ_LAT+1 edges.
- SEND1:
  - DOUT=C1, DVALID=1.
  - Hold DOUT stable while DREADY=0.
  - On transfer -> SEND2.
- SEND2:
  - DOUT=C2, DVALID=1.
  - DLAST=1 when k=NUM_REGS/2-1 and the checksum feature is off.
  - On transfer: if k is the last pair -> FIN; else k=k+1 -> RD.
- FIN:
  - DVALID=0, DONE=1 for exactly one cycle, BUSY=0 on the next cycle, go to IDLE.
- Byte order: R0, R1, R2, ..., R(NUM_REGS-1).
- Throughput: at most 2 bytes per (READ_LAT+3) cycles. No prefetch.
- ABORT=1 in any non-IDLE state:
  - Next edge goes to IDLE; DVALID and DLAST drop immediately at that edge; DONE is not pulsed.
  - A byte presented with DREADY=1 in that same cycle counts as transferred.
  - ABORT has priority over START.
- DREADY held low indefinitely: the block stalls in SEND1 or SEND2 with outputs constant.
- RESET asserted mid-dump: immediate return to the reset values above; no DONE.
- Register file writes during BUSY are undefined at the system level. The block does not guard against them.

Optional Feature:
- Macro: REG_DUMP_CHECKSUM_EN.
- Defined:
  - An extra state CSUM follows the final SEND2 instead of FIN.
  - Running sum S (DATA_WIDTH bits, modulo 2**DATA_WIDTH) is cleared on START acceptance and adds each byte on its transfer.
  - CSUM drives DOUT=S with DVALID=1 and DLAST=1; on transfer -> FIN.
  - DLAST is never asserted in SEND2.
- Undefined: no sum register or CSUM state; the stream is exactly NUM_REGS bytes.

Decomposition:
- Shared package reg_pkg:
  - REG_ADDR_W=3, REG_DATA_W=8, NUM_REGS=8.
  - State enum type dump_state_t.
- Sub-module: none required. The FSM, capture registers and optional checksum accumulator fit one module of about 200 lines.

Test Plan:
- Preload R0..R7 = 8'h10,11,...,17 via the file's write port; pulse START with DREADY=1 -> DOUT sequence 10..17; DLAST only on 17; DONE one cycle after the last transfer; BUSY low afterwards.
- Same contents, DREADY toggled 1-0-0-1 pseudo-randomly -> identical byte sequence; DOUT/DVALID unchanged during every stall cycle.
- START pulsed again while BUSY (after byte 3) -> ignored; exactly 8 bytes emitted, one DONE.
- ABORT asserted while presenting R4 with DREADY=0 -> DVALID=0 next cycle, state IDLE, no DONE; a fresh START then emits 10..17 from R0.
- RESET driven low mid-SEND2 between clock edges -> outputs reach reset values without a clock edge; READADDR1=0, READADDR2=1.
- With REG_DUMP_CHECKSUM_EN and R0..R7 = 8'hFF -> 9 bytes: eight FF then 8'hF8; DLAST only on F8.
